// File: rtl/fltadd_pkg.sv
// Shared definitions for the half-precision add sequencer.
//   state_e       : sequencer states
//   A_HI..B_LO    : byte offsets of the operand bytes inside one source record
//   STRIDE_SRC/DST: bytes per operand pair / per result
//   TIMEOUT_DEF   : default number of WAIT cycles tolerated before aborting
package fltadd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_AH,
        S_RD_AL,
        S_RD_BH,
        S_RD_BL,
        S_ISSUE,
        S_WAIT,
        S_WR_H,
        S_WR_L,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [7:0] A_HI       = 8'd0;
    localparam logic [7:0] A_LO       = 8'd1;
    localparam logic [7:0] B_HI       = 8'd2;
    localparam logic [7:0] B_LO       = 8'd3;
    localparam logic [7:0] STRIDE_SRC = 8'd4;
    localparam logic [7:0] STRIDE_DST = 8'd2;

    localparam int TIMEOUT_DEF = 64;

    // States in which a new job may be accepted and busy is low.
    function automatic logic is_rest_state(state_e s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/fltadd_addr_gen.sv
// Memory address generator for the add sequencer.
//   state_i : current sequencer state
//   src_i   : latched operand base address
//   dst_i   : latched result base address
//   idx_i   : index of the pair being processed
//   addr_o  : byte address for the data memory, 0 when no access is made
// All arithmetic is 8-bit, so addresses wrap modulo 256.
module fltadd_addr_gen
    import fltadd_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  state_e           state_i,
    input  logic [7:0]       src_i,
    input  logic [7:0]       dst_i,
    input  logic [CNT_W-1:0] idx_i,
    output logic [7:0]       addr_o
);

    logic [7:0] idx_b;
    logic [7:0] src_pair;
    logic [7:0] dst_pair;

    assign idx_b    = 8'(idx_i);
    assign src_pair = src_i + idx_b * STRIDE_SRC;
    assign dst_pair = dst_i + idx_b * STRIDE_DST;

    always_comb begin
        addr_o = 8'd0;
        case (state_i)
            S_RD_AH: addr_o = src_pair + A_HI;
            S_RD_AL: addr_o = src_pair + A_LO;
            S_RD_BH: addr_o = src_pair + B_HI;
            S_RD_BL: addr_o = src_pair + B_LO;
            S_WR_H:  addr_o = dst_pair;
            S_WR_L:  addr_o = dst_pair + 8'd1;
            default: addr_o = 8'd0;
        endcase
    end

endmodule

// File: rtl/fltadd_ctrl.sv
// Batch sequencer for half-precision additions through a shared adder.
// Fetches operand pairs byte by byte from data memory (high byte first),
// issues each pair to the adder with a go/ack handshake, writes the 16-bit
// sum back and raises done. An adder that does not answer within TIMEOUT
// WAIT cycles aborts the job into ERR.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   start, src_addr, dst_addr,
//   count                       : job request and its parameters
//   DataAddress, ReadMem,
//   WriteMem, DataIn, DataOut   : single data memory port (combinational read)
//   add_go, add_a, add_b,
//   add_ack, add_sum            : adder handshake
//   busy, done, error,
//   pairs_done                  : job status
module fltadd_ctrl
    import fltadd_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       src_addr,
    input  logic [7:0]       dst_addr,
    input  logic [CNT_W-1:0] count,
    output logic [7:0]       DataAddress,
    output logic             ReadMem,
    output logic             WriteMem,
    output logic [7:0]       DataIn,
    input  logic [7:0]       DataOut,
    output logic             add_go,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    input  logic             add_ack,
    input  logic [15:0]      add_sum,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] pairs_done
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       src_q, src_d;
    logic [7:0]       dst_q, dst_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pairs_q, pairs_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [15:0]      sum_q, sum_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] pairs_inc;

    assign pairs_inc = pairs_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            count_q <= '0;
            pairs_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            pairs_q <= pairs_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        count_d  = count_q;
        pairs_d  = pairs_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        tmo_d    = tmo_q;
        ReadMem  = 1'b0;
        WriteMem = 1'b0;
        DataIn   = 8'd0;
        add_go   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    count_d = count;
                    pairs_d = '0;
                    state_d = (count == '0) ? S_DONE : S_RD_AH;
                end
            end
            S_RD_AH: begin
                ReadMem    = 1'b1;
                a_d[15:8]  = DataOut;
                state_d    = S_RD_AL;
            end
            S_RD_AL: begin
                ReadMem    = 1'b1;
                a_d[7:0]   = DataOut;
                state_d    = S_RD_BH;
            end
            S_RD_BH: begin
                ReadMem    = 1'b1;
                b_d[15:8]  = DataOut;
                state_d    = S_RD_BL;
            end
            S_RD_BL: begin
                ReadMem    = 1'b1;
                b_d[7:0]   = DataOut;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                // An ack coincident with go is deliberately not looked at.
                add_go  = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // tmo_q counts WAIT cycles already spent without an ack.
                if (add_ack) begin
                    sum_d   = add_sum;
                    state_d = S_WR_H;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WR_H: begin
                WriteMem = 1'b1;
                DataIn   = sum_q[15:8];
                state_d  = S_WR_L;
            end
            S_WR_L: begin
                WriteMem = 1'b1;
                DataIn   = sum_q[7:0];
                pairs_d  = pairs_inc;
                state_d  = (pairs_inc == count_q) ? S_DONE : S_RD_AH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    fltadd_addr_gen #(
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .state_i (state_q),
        .src_i   (src_q),
        .dst_i   (dst_q),
        .idx_i   (pairs_q),
        .addr_o  (DataAddress)
    );

    assign add_a      = a_q;
    assign add_b      = b_q;
    assign pairs_done = pairs_q;
    assign busy       = !is_rest_state(state_q);
    assign done       = (state_q == S_DONE) || (state_q == S_ERR);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_fltadd_ctrl.sv
module tb_fltadd_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  src_addr = 8'd0;
    logic [7:0]  dst_addr = 8'd0;
    logic [5:0]  count = 6'd0;
    logic [7:0]  DataAddress;
    logic        ReadMem;
    logic        WriteMem;
    logic [7:0]  DataIn;
    logic [7:0]  DataOut;
    logic        add_go;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_ack = 1'b0;
    logic [15:0] add_sum = 16'd0;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  pairs_done;

    fltadd_ctrl #(.TIMEOUT(64), .CNT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .count       (count),
        .DataAddress (DataAddress),
        .ReadMem     (ReadMem),
        .WriteMem    (WriteMem),
        .DataIn      (DataIn),
        .DataOut     (DataOut),
        .add_go      (add_go),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_ack     (add_ack),
        .add_sum     (add_sum),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .pairs_done  (pairs_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, required nothing", name, act);
    endtask

    // Memory model: combinational read, write taken at the monitor sample point.
    logic [7:0] mem [256];
    assign DataOut = ReadMem ? mem[DataAddress] : 8'h00;

    // Stand-in adder: exact for x+x on normal numbers (exponent bump),
    // arbitrary but deterministic otherwise.
    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b);
        if (a == b) return {a[15], a[14:10] + 5'd1, a[9:0]};
        return a ^ b;
    endfunction

    // Scoreboard queues, filled when a job is launched.
    logic [7:0]  exp_rd [$];
    logic [31:0] exp_go [$];
    logic [15:0] exp_wr [$];   // {address, data}
    logic [15:0] exp_sum [64];

    task automatic push_expect(input logic [7:0] s, input logic [7:0] d, input logic [5:0] c);
        logic [7:0]  sh [256];
        logic [7:0]  ad [4];
        logic [7:0]  w;
        logic [15:0] a, b, r;
        for (int i = 0; i < 256; i++) sh[i] = mem[i];
        for (int p = 0; p < int'(c); p++) begin
            for (int j = 0; j < 4; j++) begin
                ad[j] = 8'(int'(s) + 4 * p + j);
                exp_rd.push_back(ad[j]);
            end
            a = {sh[ad[0]], sh[ad[1]]};
            b = {sh[ad[2]], sh[ad[3]]};
            exp_go.push_back({a, b});
            r = model_sum(a, b);
            exp_sum[p] = r;
            w = 8'(int'(d) + 2 * p);
            exp_wr.push_back({w, r[15:8]});
            sh[w] = r[15:8];
            w = w + 8'd1;
            exp_wr.push_back({w, r[7:0]});
            sh[w] = r[7:0];
        end
    endtask

    // Adder model: counts down k cycles after go, then acks for one cycle.
    int   ack_k      = 1;
    bit   never_ack  = 1'b0;
    bit   inject_ack = 1'b0;
    int   pend       = 0;
    logic fire_q     = 1'b0;
    logic [15:0] opa = 16'd0;
    logic [15:0] opb = 16'd0;

    always @(negedge clk) begin
        fire_q = 1'b0;
        if (add_go && !never_ack) begin
            pend = ack_k;
            opa  = add_a;
            opb  = add_b;
        end
        if (pend > 0) begin
            pend--;
            if (pend == 0) fire_q = 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        add_ack = fire_q | inject_ack;
        add_sum = fire_q ? model_sum(opa, opb) : 16'hDEAD;
    end

    // Monitor: compares every memory access and issue against the scoreboard.
    always @(negedge clk) begin
        logic [15:0] e;
        check("strobes_exclusive", ReadMem & WriteMem, 0);
        if (ReadMem) begin
            if (exp_rd.size() == 0) fail_now("unexpected_read", DataAddress);
            else check("read_addr", DataAddress, exp_rd.pop_front());
        end
        if (WriteMem) begin
            if (exp_wr.size() == 0) fail_now("unexpected_write", {DataAddress, DataIn});
            else begin
                e = exp_wr.pop_front();
                check("write_addr", DataAddress, e[15:8]);
                check("write_data", DataIn, e[7:0]);
            end
            mem[DataAddress] = DataIn;
        end
        if (!ReadMem && !WriteMem) check("idle_addr", DataAddress, 0);
        if (add_go) begin
            if (exp_go.size() == 0) fail_now("unexpected_go", {add_a, add_b});
            else check("go_operands", {add_a, add_b}, exp_go.pop_front());
        end
    end

    task automatic kick(input logic [7:0] s, input logic [7:0] d, input logic [5:0] c);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        count    = c;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) fail_now("done_timeout", cyc);
    endtask

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [5:0] cnt;
        int         k;
        int         exp_cyc;   // edges after the accepting edge until done is seen
        bit         preset;    // load 1.0 + 1.0 instead of random operands
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input vec_t v);
        int cyc;
        if (v.preset) begin
            mem[v.src]        = 8'h3C;
            mem[v.src + 8'd1] = 8'h00;
            mem[v.src + 8'd2] = 8'h3C;
            mem[v.src + 8'd3] = 8'h00;
        end else begin
            for (int i = 0; i < 4 * int'(v.cnt); i++) mem[8'(int'(v.src) + i)] = 8'($urandom);
        end
        push_expect(v.src, v.dst, v.cnt);
        ack_k     = v.k;
        never_ack = 1'b0;
        kick(v.src, v.dst, v.cnt);
        check("busy_after_start", busy, v.cnt != 0);
        check("error_cleared", error, 0);
        check("pairs_cleared", pairs_done, 0);
        wait_done(v.exp_cyc + 20, cyc);
        check("done_latency", cyc, v.exp_cyc);
        check("pairs_done", pairs_done, v.cnt);
        check("error_after_job", error, 0);
        check("busy_after_job", busy, 0);
        check("reads_left", exp_rd.size(), 0);
        check("writes_left", exp_wr.size(), 0);
        $display("job src=%0d dst=%0d count=%0d k=%0d cycles=%0d pairs_done=%0d",
                 v.src, v.dst, v.cnt, v.k, cyc, pairs_done);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vecs[0] = '{8'd128, 8'd132, 6'd1, 3, 10, 1'b1};
        vecs[1] = '{8'd250, 8'd254, 6'd3, 2, 27, 1'b0};
        vecs[2] = '{8'd0,   8'd100, 6'd0, 1, 0,  1'b0};
        vecs[3] = '{8'd10,  8'd200, 6'd5, 1, 40, 1'b0};
        vecs[4] = '{8'd40,  8'd60,  6'd4, 5, 48, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {ReadMem, WriteMem, DataAddress, DataIn, add_go, add_a, add_b, busy, done, error, pairs_done}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        check("sum_hi_1p0_plus_1p0", mem[132], 8'h40);
        check("sum_lo_1p0_plus_1p0", mem[133], 8'h00);

        // Second start while busy and stray acks in RD_BH and in the go cycle.
        for (int i = 0; i < 8; i++) mem[8'(100 + i)] = 8'($urandom);
        push_expect(8'd100, 8'd200, 6'd2);
        ack_k = 2;
        kick(8'd100, 8'd200, 6'd2);
        @(negedge clk);                              // cycle 1, RD_AH
        @(negedge clk);                              // cycle 2, RD_AL
        start = 1'b1; src_addr = 8'd0; dst_addr = 8'd16; count = 6'd1;
        inject_ack = 1'b1;                           // ack during cycle 3, RD_BH
        @(negedge clk);                              // cycle 3
        start = 1'b0;
        inject_ack = 1'b0;
        @(negedge clk);                              // cycle 4, RD_BL
        inject_ack = 1'b1;                           // ack during cycle 5, ISSUE
        @(negedge clk);                              // cycle 5
        inject_ack = 1'b0;
        wait_done(40, cyc);
        check("busy_start_latency", cyc + 4, 18);
        check("busy_start_pairs", pairs_done, 2);
        check("busy_start_error", error, 0);
        check("busy_start_writes_left", exp_wr.size(), 0);
        $display("job src=100 dst=200 count=2 with second start and stray acks, cycles=%0d", cyc + 4);

        // Timeout: the adder never answers.
        for (int i = 0; i < 8; i++) mem[8'(20 + i)] = 8'($urandom);
        push_expect(8'd20, 8'd80, 6'd2);
        never_ack = 1'b1;
        kick(8'd20, 8'd80, 6'd2);
        wait_done(100, cyc);
        check("timeout_latency", cyc, 69);
        check("timeout_error", error, 1);
        check("timeout_done", done, 1);
        check("timeout_pairs", pairs_done, 0);
        check("timeout_busy", busy, 0);
        check("timeout_reads_left", exp_rd.size(), 4);
        check("timeout_go_left", exp_go.size(), 1);
        check("timeout_writes_left", exp_wr.size(), 4);
        $display("job src=20 dst=80 count=2 adder silent, cycles=%0d error=%0d", cyc, error);
        exp_rd.delete();
        exp_go.delete();
        exp_wr.delete();
        never_ack = 1'b0;
        run_vec(vecs[3]);

        // Reset during WAIT of pair 2 (k=4: WAIT spans cycles 17..20).
        for (int i = 0; i < 12; i++) mem[8'(60 + i)] = 8'($urandom);
        push_expect(8'd60, 8'd160, 6'd3);
        ack_k = 4;
        kick(8'd60, 8'd160, 6'd3);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midjob_reset_outputs",
              {ReadMem, WriteMem, DataAddress, DataIn, add_go, add_a, add_b, busy, done, error, pairs_done}, 0);
        check("midjob_reads_left", exp_rd.size(), 4);
        check("midjob_go_left", exp_go.size(), 1);
        check("midjob_writes_left", exp_wr.size(), 4);
        check("midjob_pair1_hi", mem[160], exp_sum[0][15:8]);
        check("midjob_pair1_lo", mem[161], exp_sum[0][7:0]);
        $display("job src=60 dst=160 count=3 reset in pair 2 WAIT, pairs written before reset=1");
        exp_rd.delete();
        exp_go.delete();
        exp_wr.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fltadd_ctrl.md
# fltadd_ctrl

Sequencer that runs a batch of half-precision float additions through the shared float-add datapath. It fetches operand pairs byte-by-byte over the single data memory port and issues each pair to the adder with a go/ack handshake. It then writes each 16-bit sum back to memory and raises `done`. It sits between the top-level control (which supplies the job) and `data_mem` plus the adder core.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum number of WAIT cycles allowed per pair before the job aborts.
- `CNT_W`, 6: width of the pair count.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: job request; sampled only in IDLE, DONE or ERR.
- `src_addr`, in, 8: base byte address of the operands.
- `dst_addr`, in, 8: base byte address of the results.
- `count`, in, CNT_W: number of operand pairs.
- `DataAddress`, out, 8: memory byte address.
- `ReadMem`, out, 1: memory read strobe.
- `WriteMem`, out, 1: memory write strobe.
- `DataIn`, out, 8: write data to memory.
- `DataOut`, in, 8: read data from memory. Read is combinational and valid in the same cycle `ReadMem` is high.
- `add_go`, out, 1: one-cycle issue pulse to the adder.
- `add_a`, out, 16: operand A, held stable from `add_go` until ack.
- `add_b`, out, 16: operand B, held stable from `add_go` until ack.
- `add_ack`, in, 1: one-cycle pulse marking `add_sum` as valid.
- `add_sum`, in, 16: adder result.
- `busy`, out, 1: high in every state except IDLE, DONE and ERR.
- `done`, out, 1: job finished; held.
- `error`, out, 1: adder timeout; held.
- `pairs_done`, out, CNT_W: number of results written so far.

## Operation
- **Word format:** one 16-bit float occupies two bytes, high byte first.
  - High byte = {sign, exp[4:0], mant[9:8]}.
  - Low byte = mant[7:0].
- **Addressing for pair i:**
  - A at `src+4i` (high byte) and `src+4i+1` (low byte).
  - B at `src+4i+2` (high byte) and `src+4i+3` (low byte).
  - Sum at `dst+2i` (high byte) and `dst+2i+1` (low byte).
  - All address arithmetic is modulo 256 and wraps silently.
- **Start:** `start` is latched in IDLE, DONE or ERR. Latching captures `src_addr`, `dst_addr` and `count`, clears `done`, `error` and `pairs_done`, and enters RD_AH.
  - If `count==0`, the block goes directly to DONE instead.
  - `start` is ignored while `busy`.
- **States and transitions:**
  - RD_AH → RD_AL → RD_BH → RD_BL: `ReadMem=1` in each; the corresponding byte of `add_a`/`add_b` is captured at the clock edge.
  - ISSUE: `add_go=1`, then go to WAIT.
  - WAIT: on `add_ack`, capture `add_sum` and go to WR_H.
    - If the timeout counter reaches `TIMEOUT` with no ack, go to ERR.
  - WR_H: `WriteMem=1`, `DataIn=sum[15:8]`.
  - WR_L: `WriteMem=1`, `DataIn=sum[7:0]`; `pairs_done` increments.
    - If `pairs_done+1==count`, go to DONE; otherwise go to RD_AH for the next pair.
  - DONE: `done=1`, held until the next accepted `start` or `reset`.
  - ERR: `done=1` and `error=1`, both held. Results already written remain in memory.
- **Memory strobes:** `ReadMem` and `WriteMem` are never high in the same cycle. `DataAddress` is don't-care when neither strobe is high; drive 0.
- **Stray ack:** `add_ack` outside WAIT is ignored.
- **Ack in the go cycle:** an `add_ack` coincident with `add_go` (in ISSUE) is ignored. The adder must ack no earlier than the cycle after go.
- **Reset:** reset in any state, including mid-job, takes effect at the next edge. Outputs go to 0 immediately, with no partial write strobe, and the state returns to IDLE.

## Timing
- **Reset values:** all outputs 0 and state IDLE.
- **Ack latency:** k = number of WAIT cycles, with k≥1; k=1 means ack arrives in the cycle after go.
- **Per pair:** 4 read + 1 issue + k wait + 2 write = 7+k cycles.
- **Job:** for an accepted start at edge E0, `done` rises k+7 cycles per pair after E0. For N pairs with constant k that is N·(7+k) cycles.
  - `count==0`: `done` is high 1 cycle after E0.
- **Timeout:** ERR is entered after `TIMEOUT` WAIT cycles without ack. `error` is visible the following cycle.

## Structure
- **Package `fltadd_pkg`:**
  - State enum.
  - Byte-offset constants: A_HI=0, A_LO=1, B_HI=2, B_LO=3, STRIDE_SRC=4, STRIDE_DST=2.
  - `TIMEOUT` default.
- **Sub-module `fltadd_addr_gen`:** combinational function of state, bases and pair index producing `DataAddress` (mod 256). The FSM, operand/sum registers and timeout counter stay in `fltadd_ctrl`.

## Test plan
- **Single pair:** src=128, dst=132, count=1; memory 128..131 = 3C 00 3C 00 (1.0+1.0); adder model acks with 4000 at k=3.
  - Reads at 128..131; go carries A=3C00, B=3C00.
  - Writes 40 to 132 and 00 to 133; `done` rises 10 cycles after start; `pairs_done`=1.
- **Batch with wrap:** count=3, src=250, dst=254.
  - Reads wrap 255→0 (pair 1 at 254,255,0,1).
  - Writes at 254, 255, 0, 1, 2, 3; `done` after 3·(7+k) cycles.
- **count=0:** `done` is high 1 cycle after start; no strobes at all.
- **Timeout:** the adder never acks.
  - ERR after 64 WAIT cycles; `done=1`, `error=1`, `pairs_done`=0; no writes.
- **Reset mid-job:** assert reset during WAIT of pair 2.
  - Next cycle all outputs are 0 and state is IDLE; pair 1 results intact; a later start runs normally.
- **Start while busy and stray ack:**
  - A second `start` pulse during a job is ignored; base addresses are unchanged.
  - A stray `add_ack` during RD_BH does not advance the FSM.
